// File: rtl/uart_tx_sched_if.sv
// Signal bundle linking NREQ game-logic requesters and the UART TX FIFO write port
// to the uart_tx_sched round-robin scheduler.
interface uart_tx_sched_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0]   req;
   logic [NREQ*8-1:0] cmd;
   logic [NREQ*8-1:0] data;
   logic [NREQ-1:0]   gnt;
   logic              busy;
   logic              tx_full;
   logic              wr_uart;
   logic [7:0]        w_data;

   modport slave  (input  req, cmd, data, tx_full,
                   output gnt, busy, wr_uart, w_data);
   modport master (output req, cmd, data, tx_full,
                   input  gnt, busy, wr_uart, w_data);
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler framing (header, cmd, data) messages into the UART TX FIFO.
// Define UART_SCHED_CHECKSUM_EN to append a fourth XOR checksum byte to every frame.
module uart_tx_sched #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic           clk,
   input  logic           reset_n,
   uart_tx_sched_if.slave bus
);

`ifdef UART_SCHED_CHECKSUM_EN
   localparam logic [1:0] LAST_IDX = 2'd3;
`else
   localparam logic [1:0] LAST_IDX = 2'd2;
`endif

   typedef enum logic {IDLE, SEND} state_t;

   state_t          state_q, state_d;
   logic [IDW-1:0]  sel_q, sel_d;
   logic [IDW-1:0]  rr_q, rr_d;
   logic [7:0]      cmd_q, cmd_d;
   logic [7:0]      data_q, data_d;
   logic [1:0]      idx_q, idx_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic            busy_q, busy_d;

   logic            found;
   logic [IDW-1:0]  pick;
   logic [IDW-1:0]  cand;
   logic            wrUart;
   logic [7:0]      header;
   logic [7:0]      frameByte;

   // Scan starts at the round-robin pointer so the most recently served requester goes last.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = IDW'((int'(rr_q) + k) % NREQ);
         if (!found && bus.req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   assign header = 8'hA0 | 8'(sel_q);
   assign wrUart = (state_q == SEND) && !bus.tx_full;

   always_comb begin
      frameByte = 8'h00;
      case (idx_q)
         2'd0:    frameByte = header;
         2'd1:    frameByte = cmd_q;
         2'd2:    frameByte = data_q;
`ifdef UART_SCHED_CHECKSUM_EN
         default: frameByte = header ^ cmd_q ^ data_q;
`else
         default: frameByte = 8'h00;
`endif
      endcase
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      rr_d    = rr_q;
      cmd_d   = cmd_q;
      data_d  = data_q;
      idx_d   = idx_q;
      gnt_d   = '0;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               sel_d   = pick;
               cmd_d   = bus.cmd[8*int'(pick) +: 8];
               data_d  = bus.data[8*int'(pick) +: 8];
               rr_d    = IDW'((int'(pick) + 1) % NREQ);
               idx_d   = 2'd0;
               gnt_d   = NREQ'(1) << pick;
               state_d = SEND;
            end
         end
         SEND: begin
            // A stalled cycle leaves idx alone, so the pending byte is offered again.
            if (wrUart) begin
               if (idx_q == LAST_IDX) begin
                  idx_d   = 2'd0;
                  state_d = IDLE;
               end else begin
                  idx_d = idx_q + 2'd1;
               end
            end
         end
      endcase
      busy_d = (state_d == SEND);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         sel_q   <= '0;
         rr_q    <= '0;
         cmd_q   <= 8'h00;
         data_q  <= 8'h00;
         idx_q   <= 2'd0;
         gnt_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         rr_q    <= rr_d;
         cmd_q   <= cmd_d;
         data_q  <= data_d;
         idx_q   <= idx_d;
         gnt_q   <= gnt_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.busy    = busy_q;
   assign bus.wr_uart = wrUart;
   assign bus.w_data  = (state_q == SEND) ? frameByte : 8'h00;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scenario bench for uart_tx_sched: round-robin message model plus FIFO/grant capture,
// randomized payloads, masks and tx_full stalls.
module tb_uart_tx_sched;
   localparam int NREQ = 4;
`ifdef UART_SCHED_CHECKSUM_EN
   localparam int FLEN = 4;
`else
   localparam int FLEN = 3;
`endif

   logic clk = 1'b0;
   logic reset_n;
   int   checkCount = 0;
   int   passCount  = 0;
   int   rrModel    = 0;

   logic [7:0]      fifoQ[$];
   logic [NREQ-1:0] gntQ[$];
   logic [7:0]      expBytes[$];
   int              expGnt[$];
   logic [7:0]      cmdArr[NREQ];
   logic [7:0]      dataArr[NREQ];

   uart_tx_sched_if #(.NREQ(NREQ)) bus();

   uart_tx_sched #(.NREQ(NREQ), .IDW(2)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Everything the FIFO accepts and every grant pulse, captured away from the active edge.
   always @(negedge clk) begin
      if (reset_n) begin
         if (bus.wr_uart) fifoQ.push_back(bus.w_data);
         if (bus.gnt != '0) gntQ.push_back(bus.gnt);
      end
   end

   function automatic logic [7:0] modelByte(int sel, logic [7:0] c, logic [7:0] d, int k);
      logic [7:0] h;
      h = 8'hA0 + 8'(sel);
      case (k)
         0:       return h;
         1:       return c;
         2:       return d;
         default: return h ^ c ^ d;
      endcase
   endfunction

   // First requester at or after the model pointer wins; pointer moves just past it.
   function automatic int modelPick(logic [NREQ-1:0] mask);
      int i;
      for (int k = 0; k < NREQ; k++) begin
         i = (rrModel + k) % NREQ;
         if (mask[i]) begin
            rrModel = (i + 1) % NREQ;
            return i;
         end
      end
      return -1;
   endfunction

   function automatic void expectFrame(int sel);
      expGnt.push_back(sel);
      for (int k = 0; k < FLEN; k++) expBytes.push_back(modelByte(sel, cmdArr[sel], dataArr[sel], k));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clearQueues();
      fifoQ.delete();
      gntQ.delete();
      expBytes.delete();
      expGnt.delete();
   endtask

   task automatic setPayload(int i, logic [7:0] c, logic [7:0] d);
      cmdArr[i]  = c;
      dataArr[i] = d;
      bus.cmd[8*i +: 8]  = c;
      bus.data[8*i +: 8] = d;
   endtask

   task automatic doReset();
      reset_n     = 1'b0;
      bus.req     = '0;
      bus.tx_full = 1'b0;
      repeat (2) tick();
      reset_n = 1'b1;
      tick();
      rrModel = 0;
      clearQueues();
   endtask

   // Requesters drop their bit once granted; optional random FIFO-full stalls.
   task automatic serve(input bit stallEn, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 400; n++) begin
         tick();
         if (bus.gnt != '0) bus.req = bus.req & ~bus.gnt;
         if (stallEn) bus.tx_full = ($urandom_range(0, 3) == 0);
         if (bus.req == '0 && !bus.busy) begin
            ok = 1'b1;
            break;
         end
      end
      bus.tx_full = 1'b0;
   endtask

   task automatic test_reset();
      doReset();
      checkCount++;
      if ({bus.gnt, bus.busy, bus.wr_uart, bus.w_data} !== '0) $display("[TB] FAIL reset_idle: got %h expected 0", {bus.gnt, bus.busy, bus.wr_uart, bus.w_data});
      else passCount++;
      setPayload(0, 8'h5A, 8'hC3);
      bus.req = 4'b0001;
      tick();
      bus.req = '0;
      tick();
      #2 reset_n = 1'b0;
      #1;
      checkCount++;
      if ({bus.gnt, bus.busy, bus.wr_uart, bus.w_data} !== '0) $display("[TB] FAIL reset_async: got %h expected 0", {bus.gnt, bus.busy, bus.wr_uart, bus.w_data});
      else passCount++;
      @(negedge clk);
      #1 reset_n = 1'b1;
      rrModel = 0;
      clearQueues();
      repeat (10) tick();
      checkCount++;
      if (fifoQ.size() + gntQ.size() != 0) $display("[TB] FAIL reset_quiet: got %0d writes/grants expected 0", fifoQ.size() + gntQ.size());
      else passCount++;
   endtask

   task automatic test_single();
      int sel;
      clearQueues();
      setPayload(2, 8'h11, 8'h22);
      bus.req = 4'b0100;
      sel = modelPick(4'b0100);
      tick();
      checkCount++;
      if (bus.gnt !== NREQ'(1) << sel) $display("[TB] FAIL single_gnt: got %b expected %b", bus.gnt, NREQ'(1) << sel);
      else passCount++;
      checkCount++;
      if (bus.busy !== 1'b1) $display("[TB] FAIL single_busy: got %b expected 1", bus.busy);
      else passCount++;
      bus.req = '0;
      for (int k = 0; k < FLEN; k++) begin
         checkCount++;
         if (bus.wr_uart !== 1'b1 || bus.w_data !== modelByte(sel, 8'h11, 8'h22, k))
            $display("[TB] FAIL single_byte%0d: got wr=%b %h expected wr=1 %h", k, bus.wr_uart, bus.w_data, modelByte(sel, 8'h11, 8'h22, k));
         else passCount++;
         tick();
      end
      checkCount++;
      if (bus.busy !== 1'b0 || bus.wr_uart !== 1'b0 || bus.w_data !== 8'h00)
         $display("[TB] FAIL single_end: got busy=%b wr=%b %h expected 0 0 00", bus.busy, bus.wr_uart, bus.w_data);
      else passCount++;
   endtask

   task automatic test_round_robin();
      int  grants = 0;
      bit  ok;
      doReset();
      for (int i = 0; i < NREQ; i++) setPayload(i, 8'($urandom), 8'($urandom));
      bus.req = 4'b1011;
      for (int f = 0; f < 4; f++) expectFrame(modelPick(4'b1011));
      for (int n = 0; n < 100 && grants < 4; n++) begin
         tick();
         if (bus.gnt != '0) grants++;
      end
      bus.req = '0;
      serve(1'b0, ok);
      checkCount++;
      if (!ok || grants != 4) $display("[TB] FAIL rr_timeout: got %0d grants ok=%b expected 4 ok=1", grants, ok);
      else passCount++;
      checkCount++;
      if (gntQ.size() != expGnt.size() || fifoQ.size() != expBytes.size())
         $display("[TB] FAIL rr_count: got %0d/%0d expected %0d/%0d", gntQ.size(), fifoQ.size(), expGnt.size(), expBytes.size());
      else passCount++;
      for (int i = 0; i < expGnt.size() && i < gntQ.size(); i++) begin
         checkCount++;
         if (gntQ[i] !== NREQ'(1) << expGnt[i]) $display("[TB] FAIL rr_gnt%0d: got %b expected %b", i, gntQ[i], NREQ'(1) << expGnt[i]);
         else passCount++;
      end
      for (int i = 0; i < expBytes.size() && i < fifoQ.size(); i++) begin
         checkCount++;
         if (fifoQ[i] !== expBytes[i]) $display("[TB] FAIL rr_byte%0d: got %h expected %h", i, fifoQ[i], expBytes[i]);
         else passCount++;
      end
   endtask

   task automatic test_stall();
      bit ok;
      clearQueues();
      setPayload(0, 8'($urandom), 8'($urandom));
      bus.req = 4'b0001;
      expectFrame(modelPick(4'b0001));
      tick();
      bus.req = '0;
      tick();
      bus.tx_full = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         checkCount++;
         if (bus.wr_uart !== 1'b0 || bus.w_data !== cmdArr[0])
            $display("[TB] FAIL stall_hold%0d: got wr=%b %h expected wr=0 %h", c, bus.wr_uart, bus.w_data, cmdArr[0]);
         else passCount++;
         tick();
      end
      bus.tx_full = 1'b0;
      serve(1'b0, ok);
      checkCount++;
      if (!ok || fifoQ.size() != FLEN) $display("[TB] FAIL stall_count: got %0d bytes ok=%b expected %0d", fifoQ.size(), ok, FLEN);
      else passCount++;
      for (int i = 0; i < expBytes.size() && i < fifoQ.size(); i++) begin
         checkCount++;
         if (fifoQ[i] !== expBytes[i]) $display("[TB] FAIL stall_byte%0d: got %h expected %h", i, fifoQ[i], expBytes[i]);
         else passCount++;
      end
   endtask

   task automatic test_reset_mid();
      int sel;
      bit ok;
      clearQueues();
      setPayload(2, 8'($urandom), 8'($urandom));
      bus.req = 4'b0100;
      sel = modelPick(4'b0100);
      tick();
      bus.req = '0;
      tick();
      #2 reset_n = 1'b0;
      #1;
      checkCount++;
      if (bus.wr_uart !== 1'b0 || bus.busy !== 1'b0) $display("[TB] FAIL midreset_out: got wr=%b busy=%b expected 0 0", bus.wr_uart, bus.busy);
      else passCount++;
      @(negedge clk);
      #1 reset_n = 1'b1;
      rrModel = 0;
      checkCount++;
      if (fifoQ.size() != 1 || fifoQ[0] !== modelByte(sel, 8'h00, 8'h00, 0))
         $display("[TB] FAIL midreset_partial: got %0d bytes expected 1 header %h", fifoQ.size(), modelByte(sel, 8'h00, 8'h00, 0));
      else passCount++;
      clearQueues();
      tick();
      for (int i = 0; i < NREQ; i++) setPayload(i, 8'($urandom), 8'($urandom));
      bus.req = 4'b1010;
      sel = modelPick(4'b1010);
      tick();
      checkCount++;
      if (bus.gnt !== NREQ'(1) << sel) $display("[TB] FAIL midreset_rr: got %b expected %b", bus.gnt, NREQ'(1) << sel);
      else passCount++;
      bus.req = '0;
      serve(1'b0, ok);
      checkCount++;
      if (!ok) $display("[TB] FAIL midreset_timeout: got busy=%b expected idle", bus.busy);
      else passCount++;
   endtask

   task automatic test_ignore_during_send();
      int sel0;
      int sel3;
      bit ok;
      clearQueues();
      setPayload(0, 8'($urandom), 8'($urandom));
      bus.req = 4'b0001;
      sel0 = modelPick(4'b0001);
      expectFrame(sel0);
      tick();
      bus.req = '0;
      tick();
      setPayload(3, 8'($urandom), 8'($urandom));
      bus.req = 4'b1000;
      for (int c = 2; c <= FLEN; c++) begin
         checkCount++;
         if (bus.gnt !== '0) $display("[TB] FAIL ignore_gnt_c%0d: got %b expected 0000", c, bus.gnt);
         else passCount++;
         tick();
      end
      checkCount++;
      if (bus.gnt !== '0 || bus.busy !== 1'b0) $display("[TB] FAIL ignore_idle: got gnt=%b busy=%b expected 0000 0", bus.gnt, bus.busy);
      else passCount++;
      sel3 = modelPick(4'b1000);
      expectFrame(sel3);
      tick();
      checkCount++;
      if (bus.gnt !== NREQ'(1) << sel3) $display("[TB] FAIL ignore_next_gnt: got %b expected %b", bus.gnt, NREQ'(1) << sel3);
      else passCount++;
      bus.req = '0;
      serve(1'b0, ok);
      checkCount++;
      if (!ok || fifoQ.size() != expBytes.size()) $display("[TB] FAIL ignore_count: got %0d ok=%b expected %0d", fifoQ.size(), ok, expBytes.size());
      else passCount++;
      for (int i = 0; i < expBytes.size() && i < fifoQ.size(); i++) begin
         checkCount++;
         if (fifoQ[i] !== expBytes[i]) $display("[TB] FAIL ignore_byte%0d: got %h expected %h", i, fifoQ[i], expBytes[i]);
         else passCount++;
      end
   endtask

   task automatic test_random();
      logic [NREQ-1:0] mask;
      logic [NREQ-1:0] left;
      int sel;
      bit ok;
      for (int r = 0; r < 8; r++) begin
         clearQueues();
         mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         for (int i = 0; i < NREQ; i++) setPayload(i, 8'($urandom), 8'($urandom));
         left = mask;
         while (left != '0) begin
            sel = modelPick(left);
            left[sel] = 1'b0;
            expectFrame(sel);
         end
         bus.req = mask;
         serve(1'b1, ok);
         checkCount++;
         if (!ok || gntQ.size() != expGnt.size() || fifoQ.size() != expBytes.size())
            $display("[TB] FAIL rand%0d_count: got %0d/%0d ok=%b expected %0d/%0d", r, gntQ.size(), fifoQ.size(), ok, expGnt.size(), expBytes.size());
         else passCount++;
         for (int i = 0; i < expGnt.size() && i < gntQ.size(); i++) begin
            checkCount++;
            if (gntQ[i] !== NREQ'(1) << expGnt[i]) $display("[TB] FAIL rand%0d_gnt%0d: got %b expected %b", r, i, gntQ[i], NREQ'(1) << expGnt[i]);
            else passCount++;
         end
         for (int i = 0; i < expBytes.size() && i < fifoQ.size(); i++) begin
            checkCount++;
            if (fifoQ[i] !== expBytes[i]) $display("[TB] FAIL rand%0d_byte%0d: got %h expected %h", r, i, fifoQ[i], expBytes[i]);
            else passCount++;
         end
      end
   endtask

   initial begin
      reset_n     = 1'b0;
      bus.req     = '0;
      bus.cmd     = '0;
      bus.data    = '0;
      bus.tx_full = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_stall();
      test_reset_mid();
      test_ignore_during_send();
      test_random();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
